score_text_scanner: RTL

- Reader side of the score/label character map. Walks a fixed text window on screen and drives CHAR_ADDR into the 6-bit score character map, taking back 8-bit character codes on CHAR_DATA.
- Converts each code through the font ROM into a per-pixel TEXT_ON for the colour mapper.
- Sits between the VGA controller (DrawX/DrawY) and the colour mapper.
- 3-stage pipeline, one pixel per clock.

---
 rtl/score_text_scanner.sv | 117 +++++++++++
 1 files changed

// File: rtl/score_text_scanner.sv
// Score text scanner: 3-stage pipeline from DrawX/DrawY to per-pixel TEXT_ON via character map and font ROM.
// Optional macro SCORE_TEXT_BLINK_EN adds a VS-counted 32-on/32-off frame blink on TEXT_ON.
module score_text_scanner #(
   parameter int unsigned X0     = 480,
   parameter int unsigned Y0     = 64,
   parameter int unsigned COLS   = 7,
   parameter int unsigned ROWS   = 6,
   parameter int unsigned CHAR_W = 8,
   parameter int unsigned CHAR_H = 16
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic        PIX_VALID_IN,
   input  logic        VS,
   output logic [5:0]  CHAR_ADDR,
   input  logic [7:0]  CHAR_DATA,
   output logic [10:0] FONT_ADDR,
   input  logic [7:0]  FONT_DATA,
   output logic        TEXT_ON,
   output logic        TEXT_VALID
);
   localparam int unsigned PW  = 10;
   localparam int unsigned AW  = 6;
   localparam int unsigned FXW = 3;
   localparam int unsigned FYW = 4;
   localparam int unsigned X1  = X0 + COLS * CHAR_W;
   localparam int unsigned Y1  = Y0 + ROWS * CHAR_H;

   logic          in_win_c;
   logic [PW-1:0] dx_c;
   logic [PW-1:0] dy_c;
   logic [AW-1:0] char_addr_d;
   logic [10:0]   font_addr_d;
   logic          text_on_d;
   logic          unused_c;

   logic           v1_q, w1_q, v2_q, w2_q;
   logic [FXW-1:0] fx1_q, fx2_q;
   logic [FYW-1:0] fy1_q;
   logic [AW-1:0]  char_addr_q;
   logic [10:0]    font_addr_q;
   logic           text_on_q, text_valid_q;

`ifdef SCORE_TEXT_BLINK_EN
   logic       vs_q;
   logic [5:0] frame_q;

   // Frame counter advances on each VS falling edge.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         vs_q    <= 1'b1;
         frame_q <= '0;
      end else begin
         vs_q <= VS;
         if (vs_q && !VS) frame_q <= frame_q + 6'd1;
      end
   end
`endif

   // Window test and stage-1/2/3 next values; offsets only matter inside the window.
   always_comb begin
      in_win_c = PIX_VALID_IN
               && (DrawX >= PW'(X0)) && (DrawX < PW'(X1))
               && (DrawY >= PW'(Y0)) && (DrawY < PW'(Y1));
      dx_c        = DrawX - PW'(X0);
      dy_c        = DrawY - PW'(Y0);
      char_addr_d = '0;
      if (in_win_c) char_addr_d = AW'((dy_c >> FYW) * PW'(COLS) + (dx_c >> FXW));

      font_addr_d = '0;
      if (w1_q) font_addr_d = {CHAR_DATA[6:0], fy1_q};

      // Bit 7 of the glyph row is the leftmost pixel.
      text_on_d = w2_q & FONT_DATA[3'(CHAR_W - 1) - fx2_q];
`ifdef SCORE_TEXT_BLINK_EN
      if (frame_q[5]) text_on_d = 1'b0;
      unused_c = CHAR_DATA[7];
`else
      unused_c = ^{CHAR_DATA[7], VS};
`endif
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         v1_q         <= 1'b0;
         w1_q         <= 1'b0;
         fx1_q        <= '0;
         fy1_q        <= '0;
         char_addr_q  <= '0;
         v2_q         <= 1'b0;
         w2_q         <= 1'b0;
         fx2_q        <= '0;
         font_addr_q  <= '0;
         text_on_q    <= 1'b0;
         text_valid_q <= 1'b0;
      end else begin
         v1_q         <= PIX_VALID_IN;
         w1_q         <= in_win_c;
         fx1_q        <= dx_c[FXW-1:0];
         fy1_q        <= dy_c[FYW-1:0];
         char_addr_q  <= char_addr_d;
         v2_q         <= v1_q;
         w2_q         <= w1_q;
         fx2_q        <= fx1_q;
         font_addr_q  <= font_addr_d;
         text_on_q    <= text_on_d;
         text_valid_q <= v2_q;
      end
   end

   assign CHAR_ADDR  = char_addr_q;
   assign FONT_ADDR  = font_addr_q;
   assign TEXT_ON    = text_on_q;
   assign TEXT_VALID = text_valid_q;
endmodule
